ddr4_sref_restore_seq: RTL and testbench
========================================

// Module: ddr4_sref_restore_seq
// PURPOSE
//  Shell-side sequencer driving the DDR4 self-refresh / save-restore control set into the c0 MIG sync stage.
//  Generates shell_sys_rst_in, shell_sref_req, shell_mem_init_skip and shell_restore_complete.
//  Consumes MIG status (app_sref_ack, app_restore_en, init_calib_complete) via internal 2-FF synchronisers.
//  Runs on the always-on shell clock, so it survives the MIG UI clock stopping during MIG reset.
// PARAMETERS
//  RST_HOLD_CYCLES   64        shell_clk cycles shell_sys_rst_in is held high per MIG reset pulse (>=2)
//  ACK_TIMEOUT       4096      max cycles waiting for synced sref_ack or restore_en
//  CALIB_TIMEOUT     16777216  max cycles waiting for synced calib_complete
//  CNT_W             25        timer width; must hold max(all of the above)
// PORTS
//  shell_clk               in   1  always-on shell clock
//  shell_rst               in   1  async active-high reset
//  host_sref_enter         in   1  1-cycle pulse: enter self-refresh
//  host_sref_exit          in   1  1-cycle pulse: leave self-refresh via restore
//  host_traffic_idle       in   1  1 = no AXI/UI transactions outstanding
//  host_pause_traffic      out  1  1 = upstream must not issue new DDR traffic
//  xsdb_restore_start      out  1  1-cycle pulse to calibration-data restore engine
//  xsdb_restore_done       in   1  1-cycle pulse: restore engine finished
//  c0_ddr4_app_sref_ack    in   1  async (UI domain) self-refresh acknowledge
//  c0_ddr4_app_restore_en  in   1  async (UI domain) restore window open
//  c0_init_calib_complete  in   1  async (UI domain) calibration complete
//  shell_sys_rst_in        out  1  MIG system reset request
//  shell_sref_req          out  1  self-refresh request
//  shell_mem_init_skip     out  1  skip memory init on next calibration
//  shell_restore_complete  out  1  calibration data restored
//  seq_in_sref             out  1  1 = DRAM in self-refresh, safe to reset/reprogram
//  seq_busy                out  1  1 = any state other than RUN or SREF
//  seq_err                 out  1  sticky timeout flag; cleared only by shell_rst
//  seq_state               out  4  current state encoding (debug)
// BEHAVIOUR
//  Reset values: shell_sys_rst_in=1, host_pause_traffic=1, seq_busy=1, all other outputs 0, state=POR_RST.
//  Async inputs pass through 2-FF sync; sampled values lag by 2 cycles. xsdb_* and host_* are synchronous to shell_clk.
//  All outputs are registered. Each state change reloads the timer to 0.
//  States and transitions:
//   POR_RST  : rst_in=1, init_skip=0; after RST_HOLD_CYCLES -> POR_CAL.
//   POR_CAL  : rst_in=0; on calib -> RUN. On CALIB_TIMEOUT: set err, -> POR_RST.
//   RUN      : pause=0, busy=0. On host_sref_enter -> DRAIN. host_sref_exit ignored.
//   DRAIN    : pause=1; when traffic_idle -> SREF_REQ. No timeout.
//   SREF_REQ : sref_req=1; on ack -> SREF. On ACK_TIMEOUT: set err, sref_req=0, -> RUN.
//   SREF     : sref_req=1, in_sref=1, busy=0; on host_sref_exit -> RST_PULSE. host_sref_enter ignored.
//   RST_PULSE: rst_in=1, init_skip=1, sref_req=0, in_sref=0; after RST_HOLD_CYCLES -> WAIT_REN.
//   WAIT_REN : rst_in=0; on restore_en -> RESTORE with start pulsed once on entry. On ACK_TIMEOUT: set err, -> POR_RST.
//   RESTORE  : wait xsdb_restore_done; no timeout. On done: restore_complete=1, -> WAIT_CAL.
//   WAIT_CAL : on calib: restore_complete=0, init_skip=0, -> RUN. On CALIB_TIMEOUT: set err, -> POR_RST.
//  Any timeout that returns to POR_RST forces init_skip=0 (cold init; DRAM contents lost).
//  Simultaneous events:
//   - host_sref_enter and host_sref_exit together in RUN: enter wins.
//   - restore_done in the same cycle as restore_start: accepted as done.
//  Async reset mid-sequence returns to POR_RST; err is cleared.
//  The timer saturates and never wraps.
// STRUCTURE
//  Shared pkg ddr4_sref_pkg: state enum (4-bit), default timing constants.
//  Sub-module sync_2ff: 2-stage synchroniser with ASYNC_REG attribute, instantiated 3x.
//  FSM, timer and output registers live in this module.
// TESTING
//  1. Cold boot: release rst, model calib rising 200 cycles after rst_in falls.
//     -> rst_in high exactly 64 cycles; RUN reached 3 cycles after calib; busy=0.
//  2. Full sref/restore: enter with traffic_idle=0 for 10 cycles.
//     -> pause=1, no sref_req until idle; ack -> in_sref=1; exit -> init_skip=1, 64-cycle rst pulse;
//        restore_en -> one start pulse; done -> restore_complete=1; calib -> RUN with init_skip=0.
//  3. Ack timeout: never assert ack. -> err=1 at cycle 4096 of SREF_REQ; sref_req=0; RUN; pause=0.
//  4. Restore_en timeout after exit. -> err=1; POR_RST with init_skip=0; cold recalibration.
//  5. Async reset asserted in RESTORE. -> next cycle: rst_in=1, restore_complete=0, err=0, state=POR_RST.
//  6. Simultaneous enter+exit pulses in RUN -> DRAIN; exit pulse while in SREF_REQ -> ignored.

Source files
------------

// File: rtl/ddr4_sref_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_sref_pkg
// Shared definitions for the DDR4 self-refresh / save-restore sequencer:
//   - seq_state_t : 4-bit state encoding, also exported on seq_state
//   - DEF_*       : default timing constants used as parameter defaults
// ---------------------------------------------------------------------------
package ddr4_sref_pkg;

   typedef enum logic [3:0] {
      ST_POR_RST   = 4'd0,
      ST_POR_CAL   = 4'd1,
      ST_RUN       = 4'd2,
      ST_DRAIN     = 4'd3,
      ST_SREF_REQ  = 4'd4,
      ST_SREF      = 4'd5,
      ST_RST_PULSE = 4'd6,
      ST_WAIT_REN  = 4'd7,
      ST_RESTORE   = 4'd8,
      ST_WAIT_CAL  = 4'd9
   } seq_state_t;

   localparam int unsigned DEF_RST_HOLD_CYCLES = 64;
   localparam int unsigned DEF_ACK_TIMEOUT     = 4096;
   localparam int unsigned DEF_CALIB_TIMEOUT   = 16777216;
   localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single-bit level crossing into clk_i.
// Ports:
//   clk_i : destination clock
//   rst_i : async active-high reset (clears both stages)
//   d_i   : asynchronous input level
//   q_o   : synchronised level, two clk_i cycles behind d_i
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ddr4_sref_restore_seq.sv
// ---------------------------------------------------------------------------
// ddr4_sref_restore_seq
// Shell-side sequencer that drives the MIG c0 self-refresh / save-restore
// control set. Lives on the always-on shell clock so it keeps running while
// the MIG UI clock is stopped during a MIG reset.
// Ports:
//   shell_clk, shell_rst        : always-on clock, async active-high reset
//   host_sref_enter/exit        : 1-cycle requests from the host
//   host_traffic_idle           : no outstanding AXI/UI traffic
//   host_pause_traffic          : upstream must hold off new DDR traffic
//   xsdb_restore_start/done     : handshake with calibration restore engine
//   c0_ddr4_app_sref_ack,
//   c0_ddr4_app_restore_en,
//   c0_init_calib_complete      : MIG status (UI domain, synchronised here)
//   shell_sys_rst_in, shell_sref_req,
//   shell_mem_init_skip,
//   shell_restore_complete      : MIG control outputs
//   seq_in_sref, seq_busy,
//   seq_err, seq_state          : status / debug
// All outputs are registered and decoded from the next state.
// ---------------------------------------------------------------------------
module ddr4_sref_restore_seq
   import ddr4_sref_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
   parameter int unsigned ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
   parameter int unsigned CALIB_TIMEOUT   = DEF_CALIB_TIMEOUT,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic       shell_clk,
   input  logic       shell_rst,
   input  logic       host_sref_enter,
   input  logic       host_sref_exit,
   input  logic       host_traffic_idle,
   output logic       host_pause_traffic,
   output logic       xsdb_restore_start,
   input  logic       xsdb_restore_done,
   input  logic       c0_ddr4_app_sref_ack,
   input  logic       c0_ddr4_app_restore_en,
   input  logic       c0_init_calib_complete,
   output logic       shell_sys_rst_in,
   output logic       shell_sref_req,
   output logic       shell_mem_init_skip,
   output logic       shell_restore_complete,
   output logic       seq_in_sref,
   output logic       seq_busy,
   output logic       seq_err,
   output logic [3:0] seq_state
);

   // Timer values at which a state has spent exactly N cycles.
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CALIB_TIMEOUT - 1);

   logic ack_s, ren_s, calib_s;

   sync_2ff u_sync_ack (
      .clk_i (shell_clk), .rst_i (shell_rst),
      .d_i   (c0_ddr4_app_sref_ack), .q_o (ack_s)
   );
   sync_2ff u_sync_ren (
      .clk_i (shell_clk), .rst_i (shell_rst),
      .d_i   (c0_ddr4_app_restore_en), .q_o (ren_s)
   );
   sync_2ff u_sync_cal (
      .clk_i (shell_clk), .rst_i (shell_rst),
      .d_i   (c0_init_calib_complete), .q_o (calib_s)
   );

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             err_q, err_d;
   logic             rst_in_q, rst_in_d;
   logic             pause_q, pause_d;
   logic             busy_q, busy_d;
   logic             sref_req_q, sref_req_d;
   logic             in_sref_q, in_sref_d;
   logic             skip_q, skip_d;
   logic             complete_q, complete_d;
   logic             start_q, start_d;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;

      case (state_q)
         ST_POR_RST:   if (timer_q == RST_LAST) state_d = ST_POR_CAL;
         ST_POR_CAL: begin
            if (calib_s) begin
               state_d = ST_RUN;
            end else if (timer_q == CAL_LAST) begin
               err_d   = 1'b1;
               state_d = ST_POR_RST;
            end
         end
         // enter wins over a simultaneous exit because exit is not looked at here
         ST_RUN:       if (host_sref_enter) state_d = ST_DRAIN;
         ST_DRAIN:     if (host_traffic_idle) state_d = ST_SREF_REQ;
         ST_SREF_REQ: begin
            if (ack_s) begin
               state_d = ST_SREF;
            end else if (timer_q == ACK_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_SREF:      if (host_sref_exit) state_d = ST_RST_PULSE;
         ST_RST_PULSE: if (timer_q == RST_LAST) state_d = ST_WAIT_REN;
         ST_WAIT_REN: begin
            if (ren_s) begin
               state_d = ST_RESTORE;
            end else if (timer_q == ACK_LAST) begin
               err_d   = 1'b1;
               state_d = ST_POR_RST;
            end
         end
         // done is checked from the first RESTORE cycle, i.e. alongside start
         ST_RESTORE:   if (xsdb_restore_done) state_d = ST_WAIT_CAL;
         ST_WAIT_CAL: begin
            if (calib_s) begin
               state_d = ST_RUN;
            end else if (timer_q == CAL_LAST) begin
               err_d   = 1'b1;
               state_d = ST_POR_RST;
            end
         end
         default:      state_d = ST_POR_RST;
      endcase

      // Timer restarts on every state change and saturates instead of wrapping.
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == '1) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      // Outputs follow the state being entered so they are registered with it.
      // POR_RST never carries init_skip, so any timeout back to it is a cold init.
      rst_in_d   = (state_d == ST_POR_RST) || (state_d == ST_RST_PULSE);
      pause_d    = (state_d != ST_RUN);
      busy_d     = (state_d != ST_RUN) && (state_d != ST_SREF);
      sref_req_d = (state_d == ST_SREF_REQ) || (state_d == ST_SREF);
      in_sref_d  = (state_d == ST_SREF);
      skip_d     = (state_d == ST_RST_PULSE) || (state_d == ST_WAIT_REN) ||
                   (state_d == ST_RESTORE)   || (state_d == ST_WAIT_CAL);
      complete_d = (state_d == ST_WAIT_CAL);
      start_d    = (state_d == ST_RESTORE) && (state_q != ST_RESTORE);
   end

   always_ff @(posedge shell_clk or posedge shell_rst) begin
      if (shell_rst) begin
         state_q    <= ST_POR_RST;
         timer_q    <= '0;
         err_q      <= 1'b0;
         rst_in_q   <= 1'b1;
         pause_q    <= 1'b1;
         busy_q     <= 1'b1;
         sref_req_q <= 1'b0;
         in_sref_q  <= 1'b0;
         skip_q     <= 1'b0;
         complete_q <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         rst_in_q   <= rst_in_d;
         pause_q    <= pause_d;
         busy_q     <= busy_d;
         sref_req_q <= sref_req_d;
         in_sref_q  <= in_sref_d;
         skip_q     <= skip_d;
         complete_q <= complete_d;
         start_q    <= start_d;
      end
   end

   assign shell_sys_rst_in       = rst_in_q;
   assign host_pause_traffic     = pause_q;
   assign seq_busy               = busy_q;
   assign shell_sref_req         = sref_req_q;
   assign seq_in_sref            = in_sref_q;
   assign shell_mem_init_skip    = skip_q;
   assign shell_restore_complete = complete_q;
   assign xsdb_restore_start     = start_q;
   assign seq_err                = err_q;
   assign seq_state              = state_q;

endmodule

// File: tb/tb_ddr4_sref_restore_seq.sv
module tb_ddr4_sref_restore_seq;
   import ddr4_sref_pkg::*;

   localparam int RST_HOLD = 64;
   localparam int ACK_TO   = 4096;
   localparam int CAL_TO   = 1500;
   localparam int SYNC_LAT = 3;   // two synchroniser flops plus the state register

   logic       clk;
   logic       shell_rst;
   logic       host_sref_enter, host_sref_exit, host_traffic_idle;
   logic       host_pause_traffic;
   logic       xsdb_restore_start, xsdb_restore_done;
   logic       ack, ren, calib;
   logic       shell_sys_rst_in, shell_sref_req, shell_mem_init_skip, shell_restore_complete;
   logic       seq_in_sref, seq_busy, seq_err;
   logic [3:0] seq_state;

   int checks   = 0;
   int failures = 0;
   int start_total = 0;

   // {rst_in, pause, busy, sref_req, init_skip, restore_complete, in_sref, err, start}
   logic [8:0] outs;
   assign outs = {shell_sys_rst_in, host_pause_traffic, seq_busy, shell_sref_req,
                  shell_mem_init_skip, shell_restore_complete, seq_in_sref, seq_err,
                  xsdb_restore_start};

   ddr4_sref_restore_seq #(
      .RST_HOLD_CYCLES (RST_HOLD),
      .ACK_TIMEOUT     (ACK_TO),
      .CALIB_TIMEOUT   (CAL_TO),
      .CNT_W           (25)
   ) dut (
      .shell_clk              (clk),
      .shell_rst              (shell_rst),
      .host_sref_enter        (host_sref_enter),
      .host_sref_exit         (host_sref_exit),
      .host_traffic_idle      (host_traffic_idle),
      .host_pause_traffic     (host_pause_traffic),
      .xsdb_restore_start     (xsdb_restore_start),
      .xsdb_restore_done      (xsdb_restore_done),
      .c0_ddr4_app_sref_ack   (ack),
      .c0_ddr4_app_restore_en (ren),
      .c0_init_calib_complete (calib),
      .shell_sys_rst_in       (shell_sys_rst_in),
      .shell_sref_req         (shell_sref_req),
      .shell_mem_init_skip    (shell_mem_init_skip),
      .shell_restore_complete (shell_restore_complete),
      .seq_in_sref            (seq_in_sref),
      .seq_busy               (seq_busy),
      .seq_err                (seq_err),
      .seq_state              (seq_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (xsdb_restore_start === 1'b1) start_total++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_state(input seq_state_t st, input int budget, output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk); n++;
         if (seq_state === st) ok = 1'b1;
      end
   endtask

   task automatic pulse(input logic en, input logic ex);
      host_sref_enter = en; host_sref_exit = ex;
      @(negedge clk);
      host_sref_enter = 1'b0; host_sref_exit = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      shell_rst = 1'b1;
      host_sref_enter = 0; host_sref_exit = 0; host_traffic_idle = 0;
      xsdb_restore_done = 0; ack = 0; ren = 0; calib = 0;
      repeat (3) @(negedge clk);
      shell_rst = 1'b0;
   endtask

   task automatic count_rst_high(output int hold);
      hold = 0;
      while (shell_sys_rst_in === 1'b1 && hold < 4 * RST_HOLD) begin
         hold++; @(negedge clk);
      end
   endtask

   task automatic cold_boot(input int calib_delay, output int hold, output logic [3:0] st_after,
                            output int lat, output bit ok);
      do_reset();
      count_rst_high(hold);
      st_after = seq_state;
      repeat (calib_delay) @(negedge clk);
      calib = 1'b1;
      wait_state(ST_RUN, 20, lat, ok);
   endtask

   task automatic go_to_sref(output bit ok);
      int n;
      host_traffic_idle = 1'b1;
      pulse(1'b1, 1'b0);
      ack = 1'b1;
      wait_state(ST_SREF, 20, n, ok);
   endtask

   task automatic go_to_wait_ren(output bit ok);
      int n; bit ok1, ok2;
      go_to_sref(ok1);
      ack = 1'b0; calib = 1'b0;   // MIG reset drops its status
      pulse(1'b0, 1'b1);
      wait_state(ST_WAIT_REN, 2 * RST_HOLD, n, ok2);
      ok = ok1 && ok2;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 9'b111000000) begin
         failures++; $display("FAIL reset_outputs: got %b want 111000000", outs);
      end
      checks++;
      if (seq_state !== ST_POR_RST) begin
         failures++; $display("FAIL reset_state: got %0d want %0d", seq_state, ST_POR_RST);
      end
   endtask

   task automatic test_cold_boot();
      int hold, lat; bit ok; logic [3:0] st;
      cold_boot(200, hold, st, lat, ok);
      checks++;
      if (hold !== RST_HOLD) begin
         failures++; $display("FAIL boot_rst_hold: got %0d cycles want %0d", hold, RST_HOLD);
      end
      checks++;
      if (st !== ST_POR_CAL) begin
         failures++; $display("FAIL boot_por_cal: got state %0d want %0d", st, ST_POR_CAL);
      end
      checks++;
      if (!ok || lat !== SYNC_LAT) begin
         failures++; $display("FAIL boot_run_latency: got %0d (reached=%0d) want %0d", lat, ok, SYNC_LAT);
      end
      checks++;
      if (outs !== 9'b000000000) begin
         failures++; $display("FAIL boot_run_outputs: got %b want 000000000", outs);
      end
   endtask

   task automatic test_sref_restore(input int done_delay);
      int k, first_idle, rise, drain_len, n, hold, s0; bit ok, pause_bad;
      host_traffic_idle = 1'b0;
      pulse(1'b1, 1'b0);
      checks++;
      if (seq_state !== ST_DRAIN || host_pause_traffic !== 1'b1) begin
         failures++; $display("FAIL sr_drain_entry: got state %0d pause %b want %0d 1", seq_state, host_pause_traffic, ST_DRAIN);
      end
      // sref_req must rise exactly one cycle after the first idle sample
      drain_len = $urandom_range(8, 12);
      k = 0; first_idle = -1; rise = -1; pause_bad = 1'b0;
      while (k < 60) begin
         if (shell_sref_req === 1'b1) begin rise = k; break; end
         if (host_pause_traffic !== 1'b1) pause_bad = 1'b1;
         if (first_idle < 0 && k >= drain_len && (k >= 40 || $urandom_range(0, 3) == 0)) begin
            host_traffic_idle = 1'b1; first_idle = k;
         end
         @(negedge clk); k++;
      end
      checks++;
      if (first_idle < 0 || rise !== first_idle + 1 || pause_bad) begin
         failures++; $display("FAIL sr_drain_to_req: got rise %0d pause_bad %0d want rise %0d", rise, pause_bad, first_idle + 1);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      ack = 1'b1;
      wait_state(ST_SREF, 20, n, ok);
      checks++;
      if (!ok || n !== SYNC_LAT) begin
         failures++; $display("FAIL sr_ack_latency: got %0d want %0d", n, SYNC_LAT);
      end
      checks++;
      if (outs !== 9'b010100100) begin
         failures++; $display("FAIL sr_sref_outputs: got %b want 010100100", outs);
      end
      repeat ($urandom_range(1, 20)) @(negedge clk);
      ack = 1'b0; calib = 1'b0;
      pulse(1'b0, 1'b1);
      checks++;
      if (outs !== 9'b111010000) begin
         failures++; $display("FAIL sr_rst_pulse_outputs: got %b want 111010000", outs);
      end
      count_rst_high(hold);
      checks++;
      if (hold !== RST_HOLD || seq_state !== ST_WAIT_REN || shell_mem_init_skip !== 1'b1) begin
         failures++; $display("FAIL sr_rst_pulse_len: got %0d state %0d skip %b want %0d %0d 1", hold, seq_state, shell_mem_init_skip, RST_HOLD, ST_WAIT_REN);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
      s0 = start_total;
      ren = 1'b1;
      n = 0;
      while (n < 10 && xsdb_restore_start !== 1'b1) begin @(negedge clk); n++; end
      checks++;
      if (n !== SYNC_LAT) begin
         failures++; $display("FAIL sr_start_latency: got %0d want %0d", n, SYNC_LAT);
      end
      repeat (done_delay) @(negedge clk);
      xsdb_restore_done = 1'b1;
      @(negedge clk);
      xsdb_restore_done = 1'b0;
      ren = 1'b0;
      checks++;
      if (seq_state !== ST_WAIT_CAL || outs !== 9'b011011000) begin
         failures++; $display("FAIL sr_done_d%0d: got state %0d outs %b want %0d 011011000", done_delay, seq_state, outs, ST_WAIT_CAL);
      end
      repeat ($urandom_range(5, 60)) @(negedge clk);
      calib = 1'b1;
      wait_state(ST_RUN, 20, n, ok);
      checks++;
      if (!ok || n !== SYNC_LAT || outs !== 9'b000000000) begin
         failures++; $display("FAIL sr_back_to_run: got lat %0d outs %b want %0d 000000000", n, outs, SYNC_LAT);
      end
      checks++;
      if (start_total - s0 !== 1) begin
         failures++; $display("FAIL sr_start_count: got %0d pulses want 1", start_total - s0);
      end
   endtask

   task automatic test_simultaneous();
      int n; bit ok;
      host_traffic_idle = 1'b0;
      pulse(1'b1, 1'b1);
      checks++;
      if (seq_state !== ST_DRAIN) begin
         failures++; $display("FAIL sim_enter_exit: got state %0d want %0d", seq_state, ST_DRAIN);
      end
      host_traffic_idle = 1'b1;
      @(negedge clk);
      pulse(1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (seq_state !== ST_SREF_REQ || shell_sref_req !== 1'b1) begin
         failures++; $display("FAIL sim_exit_in_req: got state %0d sref_req %b want %0d 1", seq_state, shell_sref_req, ST_SREF_REQ);
      end
      ack = 1'b1;
      wait_state(ST_SREF, 20, n, ok);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (!ok || seq_state !== ST_SREF) begin
         failures++; $display("FAIL sim_enter_in_sref: got state %0d want %0d", seq_state, ST_SREF);
      end
   endtask

   task automatic test_ack_timeout();
      int hold, lat, cnt; bit ok, err_early, bad_state; logic [3:0] st;
      cold_boot($urandom_range(20, 100), hold, st, lat, ok);
      ack = 1'b0; host_traffic_idle = 1'b1;
      pulse(1'b1, 1'b0);
      @(negedge clk);
      cnt = 0; err_early = 1'b0; bad_state = 1'b0;
      while (shell_sref_req === 1'b1 && cnt < ACK_TO + 10) begin
         if (seq_err !== 1'b0) err_early = 1'b1;
         if (seq_state !== ST_SREF_REQ) bad_state = 1'b1;
         host_sref_exit = (cnt == 100);
         cnt++; @(negedge clk);
      end
      host_sref_exit = 1'b0;
      checks++;
      if (cnt !== ACK_TO || err_early || bad_state) begin
         failures++; $display("FAIL ack_timeout_len: got %0d early_err %0d bad_state %0d want %0d", cnt, err_early, bad_state, ACK_TO);
      end
      checks++;
      if (seq_state !== ST_RUN || outs !== 9'b000000010) begin
         failures++; $display("FAIL ack_timeout_result: got state %0d outs %b want %0d 000000010", seq_state, outs, ST_RUN);
      end
   endtask

   task automatic test_async_reset();
      int n; bit ok, ok2;
      checks++;
      if (seq_err !== 1'b1) begin
         failures++; $display("FAIL areset_err_sticky: got %b want 1", seq_err);
      end
      go_to_wait_ren(ok);
      ren = 1'b1;
      wait_state(ST_RESTORE, 10, n, ok2);
      #2 shell_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (!(ok && ok2) || seq_state !== ST_POR_RST || outs !== 9'b111000000) begin
         failures++; $display("FAIL areset_in_restore: got state %0d outs %b reached %0d want %0d 111000000", seq_state, outs, ok && ok2, ST_POR_RST);
      end
      shell_rst = 1'b0; ren = 1'b0;
   endtask

   task automatic test_ren_timeout();
      int hold, lat, cnt; bit ok; logic [3:0] st;
      cold_boot($urandom_range(20, 100), hold, st, lat, ok);
      go_to_wait_ren(ok);
      cnt = 0;
      while (seq_state === ST_WAIT_REN && cnt < ACK_TO + 10) begin cnt++; @(negedge clk); end
      checks++;
      if (!ok || cnt !== ACK_TO) begin
         failures++; $display("FAIL ren_timeout_len: got %0d want %0d", cnt, ACK_TO);
      end
      checks++;
      if (seq_state !== ST_POR_RST || outs !== 9'b111000010) begin
         failures++; $display("FAIL ren_timeout_result: got state %0d outs %b want %0d 111000010", seq_state, outs, ST_POR_RST);
      end
      count_rst_high(hold);
      repeat ($urandom_range(10, 100)) @(negedge clk);
      calib = 1'b1;
      wait_state(ST_RUN, 20, lat, ok);
      checks++;
      if (hold !== RST_HOLD || !ok || lat !== SYNC_LAT || outs !== 9'b000000010) begin
         failures++; $display("FAIL ren_recal: got hold %0d lat %0d outs %b want %0d %0d 000000010", hold, lat, outs, RST_HOLD, SYNC_LAT);
      end
   endtask

   task automatic test_calib_timeout();
      int hold, cnt;
      do_reset();
      count_rst_high(hold);
      cnt = 0;
      while (seq_state === ST_POR_CAL && cnt < CAL_TO + 10) begin
         if (seq_err !== 1'b0) cnt = CAL_TO + 100;
         cnt++; @(negedge clk);
      end
      checks++;
      if (hold !== RST_HOLD || cnt !== CAL_TO) begin
         failures++; $display("FAIL cal_timeout_len: got hold %0d cnt %0d want %0d %0d", hold, cnt, RST_HOLD, CAL_TO);
      end
      checks++;
      if (seq_state !== ST_POR_RST || outs !== 9'b111000010) begin
         failures++; $display("FAIL cal_timeout_result: got state %0d outs %b want %0d 111000010", seq_state, outs, ST_POR_RST);
      end
   endtask

   initial begin
      shell_rst = 1'b1;
      host_sref_enter = 0; host_sref_exit = 0; host_traffic_idle = 0;
      xsdb_restore_done = 0; ack = 0; ren = 0; calib = 0;
      test_reset();
      test_cold_boot();
      test_sref_restore($urandom_range(1, 10));
      test_sref_restore(0);
      test_simultaneous();
      test_ack_timeout();
      test_async_reset();
      test_ren_timeout();
      test_calib_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
